seq_mant_mul: RTL and testbench
===============================

Name: seq_mant_mul

Overview:
- Sequential shift-add mantissa multiplier; the responder side of the startMul/doneMul handshake issued by the FP multiplier control unit.
- Captures two unsigned mantissas on startMul, computes the full-width product over WIDTH cycles, then raises doneMul.
- Sits in the FP multiplier datapath. Its product feeds normalisation/rounding, and exponent logic runs in parallel.

Parameters:
- WIDTH, 24, mantissa width including hidden bit; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- startMul  input  1  start request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; sampled with startMul.
- b  input  WIDTH  multiplier; sampled with startMul.
- doneMul  output  1  high while idle with a valid (or reset) product.
- product  output  2*WIDTH  unsigned a*b; valid whenever doneMul=1.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, doneMul=1, product=0, all internal registers 0, step counter 0. Reset mid-operation aborts the operation; no partial result survives.
- States: IDLE, BUSY. doneMul is decoded from state (1 in IDLE, 0 in BUSY); it is never registered separately.
- IDLE, startMul=1 at edge t:
  - mcand<=a; {acc_hi, mplr}<={(WIDTH+1)'0, b}; cnt<=0; state<=BUSY.
  - doneMul is 0 from cycle t+1. The controller's wait_mul check in the cycle after go therefore never sees a stale done.
- BUSY, each edge:
  - sum = (mplr[0] ? acc_hi[WIDTH-1:0]+mcand : acc_hi[WIDTH-1:0]), computed WIDTH+1 bits wide.
  - {acc_hi, mplr} <= {1'b0, sum, mplr} >> 1, i.e. acc_hi<=sum>>1 (zero-extended), mplr<={sum[0], mplr[WIDTH-1:1]}.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1: state<=IDLE.
- Latency: start sampled at edge t → BUSY for exactly WIDTH cycles → doneMul=1 from t+WIDTH+1 (cycle 25 for WIDTH=24).
- product = {acc_hi[WIDTH-1:0], mplr}.
  - Held stable throughout IDLE until the next accepted start.
  - Value during BUSY is unspecified; consumers must not sample it.
- cnt is $clog2(WIDTH)+1 bits; no wrap is possible within an operation.
- startMul while BUSY: ignored, with no queuing and no effect on the operation.
- startMul held high continuously: the operation restarts on the first IDLE edge, so doneMul pulses high for exactly one cycle between operations.
- a, b may change freely after the sampling edge.
- No overflow is possible: the product of two WIDTH-bit values fits in 2*WIDTH bits.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: if a==0 or b==0 at the sampling edge, the block enters BUSY for exactly one cycle, forces the product registers to 0, and returns to IDLE. doneMul rises at t+2.
- Undefined: zero operands take the full WIDTH-cycle path; the result is still 0.
- Non-zero operands behave identically in both builds.

Decomposition:
- fp_mul_pkg holds:
  - MANT_W=24 constant, used as the WIDTH default.
  - mul_state_t enum {IDLE, BUSY}.
  - 2*MANT_W product typedef, shared with the normaliser.
- No sub-module: the adder and shifter stay inline. The FSM and datapath live in one always_ff plus one always_comb.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY (cycle 10 of 24) → doneMul=1 and product=0 immediately; the next start with a=3, b=5 yields 15 at cycle 25.
- a=24'h000003, b=24'h000005, 1-cycle startMul → doneMul=0 on cycles 1..24, doneMul=1 on cycle 25, product=48'h00000000000F.
- a=b=24'hFFFFFF → product=48'hFFFFFE000001 at cycle 25; a=b=24'hC00000 (1.5×1.5) → 48'h900000000000.
- startMul re-pulsed at cycles 5 and 12 with different operands during BUSY → ignored; the original product is returned and latency is unchanged.
- startMul held high for 60 cycles with fixed operands → doneMul high only on cycles 25 and 50, one cycle each; product correct at each.
- MUL_ZERO_BYPASS_EN build: a=0, b=24'h800000 → doneMul=0 on cycle 1, 1 on cycle 2, product=0. Same stimulus without the macro → doneMul=1 at cycle 25, product=0.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared FP multiplier datapath definitions: mantissa width, the sequential
// multiplier's state encoding, and the full-width product type that the
// normaliser also consumes.
package fp_mul_pkg;

    // Mantissa width including the hidden bit.
    localparam int MANT_W = 24;

    // Sequential multiplier control states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    // Full-width mantissa product.
    typedef logic [2*MANT_W-1:0] mant_prod_t;

endpackage : fp_mul_pkg

// File: rtl/seq_mant_mul.sv
// Sequential shift-add mantissa multiplier.
//
// Handshake (responder side of startMul/doneMul):
//   doneMul=1 means the block is idle and product holds a valid result (or
//   zero after reset). startMul is sampled only while doneMul=1; a and b are
//   captured on that same edge and may change afterwards. doneMul drops on
//   the cycle after the accepted start and rises again once product is final.
//   startMul while busy is ignored and never queued.
//
// Timing: a start accepted at edge t keeps the block busy for WIDTH cycles;
// doneMul reads 1 again from cycle t+WIDTH+1.
//
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand makes the block
// busy for a single cycle, clears the product and returns to idle, so
// doneMul reads 1 again from cycle t+2. Without it, zero operands take the
// full WIDTH-cycle path and still produce zero.
module seq_mant_mul
    import fp_mul_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 startMul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 doneMul,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Architectural state
    mul_state_t          state;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH:0]      acc_hi;
    logic [WIDTH-1:0]    mplr;
    logic [CNT_W-1:0]    cnt;

    // Next-state values
    mul_state_t          state_n;
    logic [WIDTH-1:0]    mcand_n;
    logic [WIDTH:0]      acc_hi_n;
    logic [WIDTH-1:0]    mplr_n;
    logic [CNT_W-1:0]    cnt_n;
    logic [WIDTH:0]      sum;

`ifdef MUL_ZERO_BYPASS_EN
    // Set for the single busy cycle of a zero-operand operation.
    logic                zero_byp;
    logic                zero_byp_n;
`endif

    // Next-state and datapath: capture on accepted start, one shift-add step per busy cycle.
    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        acc_hi_n = acc_hi;
        mplr_n   = mplr;
        cnt_n    = cnt;
`ifdef MUL_ZERO_BYPASS_EN
        zero_byp_n = zero_byp;
`endif
        // acc_hi[WIDTH] is always 0 between steps, so a full-width add is exact.
        sum = mplr[0] ? (acc_hi + {1'b0, mcand}) : acc_hi;

        case (state)
            IDLE: begin
                if (startMul) begin
                    mcand_n  = a;
                    acc_hi_n = '0;
                    mplr_n   = b;
                    cnt_n    = '0;
                    state_n  = BUSY;
`ifdef MUL_ZERO_BYPASS_EN
                    zero_byp_n = (a == '0) || (b == '0);
`endif
                end
            end
            BUSY: begin
`ifdef MUL_ZERO_BYPASS_EN
                if (zero_byp) begin
                    acc_hi_n   = '0;
                    mplr_n     = '0;
                    zero_byp_n = 1'b0;
                    state_n    = IDLE;
                end else begin
                    acc_hi_n = {1'b0, sum[WIDTH:1]};
                    mplr_n   = {sum[0], mplr[WIDTH-1:1]};
                    cnt_n    = cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state_n = IDLE;
                    end
                end
`else
                acc_hi_n = {1'b0, sum[WIDTH:1]};
                mplr_n   = {sum[0], mplr[WIDTH-1:1]};
                cnt_n    = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            mplr   <= '0;
            cnt    <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            zero_byp <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            mcand  <= mcand_n;
            acc_hi <= acc_hi_n;
            mplr   <= mplr_n;
            cnt    <= cnt_n;
`ifdef MUL_ZERO_BYPASS_EN
            zero_byp <= zero_byp_n;
`endif
        end
    end

    // Done is a pure decode of the state; product is the concatenated shift register.
    assign doneMul = (state == IDLE);
    assign product = {acc_hi[WIDTH-1:0], mplr};

endmodule : seq_mant_mul

// File: tb/tb_seq_mant_mul.sv
// Directed bench for seq_mant_mul (default WIDTH=24). Cycle k after an
// accepted start is the clock period following the k-th rising edge counted
// from the sampling edge; outputs are sampled on falling edges.
module tb_seq_mant_mul;
    import fp_mul_pkg::*;

    localparam int W = MANT_W;

`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = W + 1;
`endif

    // Clock / reset
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             startMul = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             doneMul;
    logic [2*W-1:0]   product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mant_mul dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .startMul (startMul),
        .a        (a),
        .b        (b),
        .doneMul  (doneMul),
        .product  (product)
    );

    // Scoreboard comparison
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver: one start pulse, optional busy-time re-pulses, then wait for done
    task automatic do_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic [2*W-1:0] exp_prod, input int exp_lat, input bit repulse);
        int lat;
        lat = 0;
        @(negedge clk);
        a = op_a;
        b = op_b;
        startMul = 1'b1;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                startMul = 1'b0;
                a = $urandom_range(1, 255);
                b = $urandom_range(1, 255);
            end
            if (repulse && (c == 5 || c == 12)) begin
                a = 24'h000007;
                b = 24'h000009;
                startMul = 1'b1;
            end else if (repulse && (c == 6 || c == 13)) begin
                startMul = 1'b0;
            end
            if (doneMul) lat = c;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_prod"}, 64'(product), 64'(exp_prod));
        // Product must hold while idle
        @(negedge clk);
        check({tag, "_hold"}, 64'(product), 64'(exp_prod));
    endtask

    initial begin
        int highs;
        int first_hi;
        int second_hi;
        int waited;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", 64'(doneMul), 64'd1);
        check("rst_prod", 64'(product), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 64'(doneMul), 64'd1);

        // Basic products
        do_op("mul_3x5", 24'h000003, 24'h000005, 48'h00000000000F, W + 1, 1'b0);
        do_op("mul_max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, W + 1, 1'b0);
        do_op("mul_1p5", 24'hC00000, 24'hC00000, 48'h900000000000, W + 1, 1'b0);
        do_op("mul_pow2", 24'h800000, 24'h000002, 48'h000001000000, W + 1, 1'b0);

        // Starts during BUSY are ignored
        do_op("busy_ign", 24'h000003, 24'h000005, 48'h00000000000F, W + 1, 1'b1);

        // Reset in the middle of an operation
        @(negedge clk);
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        startMul = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) startMul = 1'b0;
            if (c == 9) check("pre_rst_busy", 64'(doneMul), 64'd0);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", 64'(doneMul), 64'd1);
        check("mid_rst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 24'h000003, 24'h000005, 48'h00000000000F, W + 1, 1'b0);

        // startMul held high: done pulses for one cycle between back-to-back ops
        highs = 0;
        first_hi = 0;
        second_hi = 0;
        @(negedge clk);
        a = 24'h000010;
        b = 24'h000020;
        startMul = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (doneMul) begin
                highs++;
                if (highs == 1) first_hi = c;
                if (highs == 2) second_hi = c;
                check("hold_prod", 64'(product), 64'h200);
            end
        end
        startMul = 1'b0;
        check("hold_highs", 64'(highs), 64'd2);
        check("hold_first", 64'(first_hi), 64'(W + 1));
        check("hold_second", 64'(second_hi), 64'(2 * W + 2));
        waited = 0;
        while (!doneMul && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check("hold_drain_done", 64'(doneMul), 64'd1);
        check("hold_drain_prod", 64'(product), 64'h200);

        // Zero operands
        do_op("zero_a", 24'h000000, 24'h800000, 48'h0, ZERO_LAT, 1'b0);
        do_op("zero_b", 24'h123456, 24'h000000, 48'h0, ZERO_LAT, 1'b0);
        do_op("nz_after_zero", 24'h000100, 24'h000100, 48'h000000010000, W + 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mant_mul
